arbitro_quintuplicador: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational quintuplicador (signed 6-bit A -> 12-bit F = 5*A) between two requesters.
- Grants one requester, drives the shared quintuplicador input, registers its output, and returns the result with a valid/ready handshake tagged by requester id.
- Sits between the ALU operand sources and the single quintuplicador instance in the ALU datapath.

---
 rtl/arbitro_quintuplicador.sv | 126 ++++++++++++
 tb/tb_arbitro_quintuplicador.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/arbitro_quintuplicador.sv
// Round-robin arbiter/sequencer sharing one quintuplicador (F = 5*A) between two requesters.
// Optional build macro QUIN_CHECK_EN adds a reference check of quin_f reported on res_err.
module arbitro_quintuplicador #(
  parameter int unsigned ANCHO_A = 6,
  parameter int unsigned ANCHO_F = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [ANCHO_A-1:0] a0,
  output logic               ack0,
  input  logic               req1,
  input  logic [ANCHO_A-1:0] a1,
  output logic               ack1,
  output logic [ANCHO_A-1:0] quin_a,
  input  logic [ANCHO_F-1:0] quin_f,
  output logic               res_valid,
  output logic               res_id,
  output logic [ANCHO_F-1:0] res_f,
  input  logic               res_ready,
  output logic               res_err
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] CALC    = 2'd1;
  localparam logic [1:0] ENTREGA = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               prio_q, prio_d;
  logic               gnt_q, gnt_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic [ANCHO_A-1:0] quin_a_q, quin_a_d;
  logic               res_valid_q, res_valid_d;
  logic               res_id_q, res_id_d;
  logic [ANCHO_F-1:0] res_f_q, res_f_d;
  logic               res_err_q, res_err_d;
  logic               gnt_c;
  logic               mismatch_c;

  // Contention goes to prio; a lone request wins outright.
  assign gnt_c = (req0 && req1) ? prio_q : req1;

`ifdef QUIN_CHECK_EN
  logic [ANCHO_F-1:0] quin_ref_c;
  assign quin_ref_c = ANCHO_F'($signed(quin_a_q)) * ANCHO_F'(5);
  assign mismatch_c = (quin_ref_c != quin_f);
`else
  assign mismatch_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    gnt_d       = gnt_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    quin_a_d    = quin_a_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_f_d     = res_f_q;
    res_err_d   = res_err_q;
    case (state_q)
      OCIOSO: begin
        if (req0 || req1) begin
          gnt_d    = gnt_c;
          prio_d   = ~gnt_c;
          quin_a_d = gnt_c ? a1 : a0;
          ack0_d   = ~gnt_c;
          ack1_d   = gnt_c;
          state_d  = CALC;
        end
      end
      CALC: begin
        res_f_d     = quin_f;
        res_id_d    = gnt_q;
        res_valid_d = 1'b1;
        res_err_d   = mismatch_c;
        state_d     = ENTREGA;
      end
      ENTREGA: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          state_d     = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCIOSO;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      quin_a_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_f_q     <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      gnt_q       <= gnt_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      quin_a_q    <= quin_a_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_f_q     <= res_f_d;
      res_err_q   <= res_err_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign quin_a    = quin_a_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_f     = res_f_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_arbitro_quintuplicador.sv
// Bench for arbitro_quintuplicador: directed cases then random traffic against an arithmetic model.
// Honours QUIN_CHECK_EN when predicting res_err.
module tb_arbitro_quintuplicador;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, ack0, ack1;
  logic [5:0]  a0, a1, quin_a;
  logic [11:0] quin_f, res_f;
  logic        res_valid, res_id, res_ready, res_err;
  logic signed [5:0] qa_s;
  bit          bad_f;
  bit          prio_m;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  // Shared multiplier model; bad_f stands in for a broken unit.
  assign qa_s   = quin_a;
  assign quin_f = bad_f ? 12'h000 : 12'(int'(qa_s) * 5);

  arbitro_quintuplicador dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .ack0(ack0),
    .req1(req1), .a1(a1), .ack1(ack1),
    .quin_a(quin_a), .quin_f(quin_f),
    .res_valid(res_valid), .res_id(res_id), .res_f(res_f),
    .res_ready(res_ready), .res_err(res_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
    #2;
    chk("reset", {ack0, ack1, quin_a, res_valid, res_id, res_f, res_err}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    prio_m = 1'b0;
  endtask

  // Wait (bounded) for a grant and check it against the round-robin rule.
  task automatic arb_grant(output bit g, output logic [5:0] ga, output int waited);
    bit exp_g;
    exp_g = (req0 && req1) ? prio_m : req1;
    ga = exp_g ? a1 : a0;
    waited = 0;
    do begin
      step;
      waited++;
    end while (!(ack0 || ack1) && waited < 8);
    chk("ack", {ack1, ack0}, exp_g ? 32'd2 : 32'd1);
    chk("quin_a", quin_a, ga);
    prio_m = ~exp_g;
    if (exp_g) req1 = 1'b0; else req0 = 1'b0;
    g = exp_g;
  endtask

  task automatic deliver(input bit g, input logic [5:0] a, input int hold);
    logic signed [5:0] as;
    logic [11:0] ef;
    bit ee;
    as = a;
    ef = bad_f ? 12'h000 : 12'(int'(as) * 5);
`ifdef QUIN_CHECK_EN
    ee = bad_f && (12'(int'(as) * 5) != 12'h000);
`else
    ee = 1'b0;
`endif
    res_ready = 1'b0;
    step;
    chk("result", {ack1, ack0, res_valid, res_id, res_f}, {2'b00, 1'b1, g, ef});
    chk("res_err", res_err, ee);
    for (int i = 0; i < hold; i++) begin
      step;
      chk("hold", {ack1, ack0, res_valid, res_id, res_f, res_err}, {2'b00, 1'b1, g, ef, ee});
    end
    res_ready = 1'b1;
    step;
    chk("accept", {res_valid, res_err}, 32'd0);
    res_ready = 1'b0;
  endtask

  task automatic txn(input int hold);
    bit g;
    logic [5:0] ga;
    int w;
    arb_grant(g, ga, w);
    deliver(g, ga, hold);
  endtask

  initial begin
    bit g;
    logic [5:0] ga;
    int w;
    bad_f = 1'b0;
    a0 = '0; a1 = '0;
    do_reset;

    // Single request, a0 = -2
    req0 = 1'b1; a0 = 6'h3E;
    arb_grant(g, ga, w);
    chk("quin_a_m2", quin_a, 32'h3E);
    deliver(g, ga, 2);
    chk("res_f_m2", res_f, 32'hFF6);

    // Simultaneous requests after reset: requester 0 first
    do_reset;
    req0 = 1'b1; a0 = 6'd3; req1 = 1'b1; a1 = 6'd9;
    txn(0);
    chk("res_f_3", res_f, 32'h00F);
    txn(0);
    chk("res_f_9", {res_id, res_f}, {1'b1, 12'h02D});

    // Extremes on requester 1
    req1 = 1'b1; a1 = 6'h20;
    txn(0);
    chk("res_f_min", res_f, 32'hF60);
    req1 = 1'b1; a1 = 6'h1F;
    txn(1);
    chk("res_f_max", res_f, 32'h09B);

    // Backpressure with requester 1 waiting
    req0 = 1'b1; a0 = 6'd7;
    arb_grant(g, ga, w);
    req1 = 1'b1; a1 = 6'd5;
    deliver(g, ga, 5);
    arb_grant(g, ga, w);
    chk("bp_ack_delay", w, 32'd1);
    deliver(g, ga, 0);

    // Reset while a result sits in ENTREGA
    req0 = 1'b1; a0 = 6'd9;
    arb_grant(g, ga, w);
    step;
    chk("pending", {res_valid, res_f}, {1'b1, 12'h02D});
    req0 = 1'b1; req1 = 1'b1; a1 = 6'h3B;
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {res_valid, res_f, ack0, ack1}, 32'd0);
    prio_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(0);
    chk("rearb_id", res_id, 32'd0);
    txn(0);

    // Faulty multiplier, then a healthy one
    bad_f = 1'b1;
    req0 = 1'b1; a0 = 6'd4;
    txn(1);
    bad_f = 1'b0;
    req0 = 1'b1; a0 = 6'd4;
    arb_grant(g, ga, w);
    step;
    chk("res_f_4", {res_f, res_err}, {12'h014, 1'b0});
    res_ready = 1'b1;
    step;
    res_ready = 1'b0;

    // Random traffic
    repeat (40) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; a0 = 6'($urandom); end
      if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; a1 = 6'($urandom); end
      if (!req0 && !req1) begin req0 = 1'b1; a0 = 6'($urandom); end
      txn($urandom_range(0, 3));
    end
    repeat (2) if (req0 || req1) txn(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
